// File: rtl/sprite_io_arbiter_if.sv
// Bus bundle between the CPU I/O port, the sprite renderer and the sprite RAM.
// The arbiter connects through the slave modport; the environment uses master.
interface sprite_io_arbiter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int RAM_AW     = 9
);
  logic [15:0]           io_addr;
  logic                  io_write;
  logic [DATA_WIDTH-1:0] io_wr_data;
  logic [DATA_WIDTH-1:0] io_rd_data;
  logic                  vid_req;
  logic [RAM_AW-1:0]     vid_addr;
  logic                  vid_grant;
  logic                  vid_valid;
  logic [DATA_WIDTH-1:0] vid_rd_data;
  logic [RAM_AW-1:0]     ram_addr;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_wr_data;
  logic [DATA_WIDTH-1:0] ram_rd_data;

  modport slave (
    input  io_addr, io_write, io_wr_data, vid_req, vid_addr, ram_rd_data,
    output io_rd_data, vid_grant, vid_valid, vid_rd_data, ram_addr, ram_we, ram_wr_data
  );

  modport master (
    output io_addr, io_write, io_wr_data, vid_req, vid_addr, ram_rd_data,
    input  io_rd_data, vid_grant, vid_valid, vid_rd_data, ram_addr, ram_we, ram_wr_data
  );
endinterface

// File: rtl/sprite_io_arbiter.sv
// Shares the sprite attribute RAM between posted CPU I/O writes (via a small FIFO)
// and the video renderer, which has read priority up to a starvation limit.
module sprite_io_arbiter #(
  parameter int         DATA_WIDTH   = 16,
  parameter int         RAM_AW       = 9,
  parameter logic [3:0] IO_BASE      = 4'h8,
  parameter int         FIFO_DEPTH   = 4,
  parameter int         STARVE_LIMIT = 8
) (
  input logic clock,
  input logic reset,
  sprite_io_arbiter_if.slave bus
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [RAM_AW-1:0]     fifo_addr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count, count_nxt;
  logic [SW-1:0]         starve_cnt;
  logic                  overflow;
  logic                  vld_p1;

  logic sel, is_status, is_data;
  logic empty, full;
  logic wr_slot, vid_slot;
  logic push_req, push, pop, ovf_set, ovf_clr;

  function automatic logic [DATA_WIDTH-1:0] status_word(
    input logic ovf, input logic fl, input logic em, input logic [CW-1:0] cnt
  );
    logic [DATA_WIDTH-1:0] w;
    w       = '0;
    w[15]   = ovf;
    w[14]   = fl;
    w[13]   = em;
    w[3:0]  = 4'(cnt);
    return w;
  endfunction

  always_comb begin
    sel       = (bus.io_addr[15:12] == IO_BASE);
    is_status = sel && (bus.io_addr[11:0] == 12'hFFF);
    is_data   = sel && !is_status;
    empty     = (count == '0);
    full      = (count == CW'(FIFO_DEPTH));
    wr_slot   = !empty && (!bus.vid_req || starve_cnt == SW'(STARVE_LIMIT));
    vid_slot  = bus.vid_req && !wr_slot;
    pop       = wr_slot;
    push_req  = bus.io_write && is_data;
    // A full FIFO still accepts when the head leaves in the same cycle.
    push      = push_req && (!full || pop);
    ovf_set   = push_req && !push;
    ovf_clr   = bus.io_write && is_status && bus.io_wr_data[0];
    count_nxt = count + CW'(push) - CW'(pop);
  end

  always_comb begin
    bus.io_rd_data  = status_word(overflow, full, empty, count);
    bus.ram_we      = wr_slot && reset;
    bus.vid_grant   = vid_slot && reset;
    bus.ram_addr    = wr_slot ? fifo_addr[rd_ptr] : bus.vid_addr;
    bus.ram_wr_data = fifo_data[rd_ptr];
    bus.vid_valid   = vld_p1;
    bus.vid_rd_data = vld_p1 ? bus.ram_rd_data : '0;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      starve_cnt <= '0;
      vld_p1     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_nxt;
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
      if (wr_slot || count_nxt == '0) starve_cnt <= '0;
      else if (vid_slot && !empty)    starve_cnt <= starve_cnt + SW'(1);
      // stage p0 -> p1: RAM read issued on grant, data returns next cycle
      vld_p1 <= vid_slot;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_addr[wr_ptr] <= bus.io_addr[RAM_AW-1:0];
      fifo_data[wr_ptr] <= bus.io_wr_data;
    end
  end
endmodule

// File: tb/tb_sprite_io_arbiter.sv
// Directed bench for sprite_io_arbiter with a registered-read RAM model.
module tb_sprite_io_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   hi_writes = 0;
  logic [15:0] ram_mem [512];

  sprite_io_arbiter_if #(.DATA_WIDTH(16), .RAM_AW(9)) bus ();

  sprite_io_arbiter #(
    .DATA_WIDTH(16), .RAM_AW(9), .IO_BASE(4'h8), .FIFO_DEPTH(4), .STARVE_LIMIT(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.slave)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_wr_data;
    bus.ram_rd_data <= ram_mem[bus.ram_addr];
    if (bus.ram_we && bus.ram_addr[8]) hi_writes <= hi_writes + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_io(input logic [15:0] a, input logic w, input logic [15:0] d);
    bus.io_addr    = a;
    bus.io_write   = w;
    bus.io_wr_data = d;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) ram_mem[i] = 16'h0;
    bus.ram_rd_data = 16'h0;
    set_io(16'h0, 1'b0, 16'h0);
    bus.vid_req  = 1'b0;
    bus.vid_addr = 9'h0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("rst_status", bus.io_rd_data, 16'h2000);
    check("rst_vvalid", bus.vid_valid, 1'b0);
    check("rst_we", bus.ram_we, 1'b0);

    // Posted write drained on the next cycle
    set_io(16'h8005, 1'b1, 16'h1234);
    #1 check("push_cycle_we", bus.ram_we, 1'b0);
    tick();
    set_io(16'h0, 1'b0, 16'h0);
    #1;
    check("drain_we", bus.ram_we, 1'b1);
    check("drain_addr", bus.ram_addr, 9'h005);
    check("drain_data", bus.ram_wr_data, 16'h1234);
    check("drain_status", bus.io_rd_data, 16'h0001);
    tick();
    check("empty_after_pop", bus.io_rd_data, 16'h2000);

    // Video read of the freshly written location
    bus.vid_req  = 1'b1;
    bus.vid_addr = 9'h005;
    #1;
    check("rd_grant", bus.vid_grant, 1'b1);
    check("rd_addr", bus.ram_addr, 9'h005);
    check("rd_we", bus.ram_we, 1'b0);
    tick();
    bus.vid_req = 1'b0;
    #1;
    check("rd_valid", bus.vid_valid, 1'b1);
    check("rd_data", bus.vid_rd_data, 16'h1234);
    tick();
    check("rd_valid_drop", bus.vid_valid, 1'b0);

    // Writes outside this block's I/O window are ignored
    set_io(16'h1005, 1'b1, 16'hFFFF);
    tick();
    set_io(16'h0, 1'b0, 16'h0);
    #1 check("unsel_ignored", bus.io_rd_data, 16'h2000);

    // Starvation limit: 8 grants with a pending write, then a write slot
    bus.vid_req  = 1'b1;
    bus.vid_addr = 9'h020;
    set_io(16'h8010, 1'b1, 16'hBEEF);
    #1 check("starve_c0_grant", bus.vid_grant, 1'b1);
    tick();
    set_io(16'h0, 1'b0, 16'h0);
    for (int i = 1; i <= 8; i++) begin
      #1;
      check($sformatf("starve_grant_%0d", i), bus.vid_grant, 1'b1);
      check($sformatf("starve_we_%0d", i), bus.ram_we, 1'b0);
      tick();
    end
    #1;
    check("slot_grant", bus.vid_grant, 1'b0);
    check("slot_we", bus.ram_we, 1'b1);
    check("slot_addr", bus.ram_addr, 9'h010);
    check("slot_data", bus.ram_wr_data, 16'hBEEF);
    tick();
    check("after_slot_grant", bus.vid_grant, 1'b1);
    check("after_slot_we", bus.ram_we, 1'b0);
    check("after_slot_vvalid", bus.vid_valid, 1'b0);
    check("after_slot_status", bus.io_rd_data, 16'h2000);

    // Overflow: 5 back-to-back writes while video holds the RAM
    for (int i = 0; i < 5; i++) begin
      set_io(16'h8100 + 16'(i), 1'b1, 16'h1000 + 16'(i));
      tick();
    end
    set_io(16'h0, 1'b0, 16'h0);
    #1 check("ovf_status", bus.io_rd_data, 16'hC004);
    tick();
    set_io(16'h8FFF, 1'b1, 16'h0001);
    #1 check("clr_cycle_status", bus.io_rd_data, 16'hC004);
    tick();
    set_io(16'h0, 1'b0, 16'h0);
    #1;
    check("ovf_cleared", bus.io_rd_data, 16'h4004);
    check("ovf_grant", bus.vid_grant, 1'b1);
    reset = 1'b0;
    #1;
    check("rst4_grant", bus.vid_grant, 1'b0);
    check("rst4_we", bus.ram_we, 1'b0);
    tick();
    reset = 1'b1;
    bus.vid_req = 1'b0;
    #1 check("rst4_status", bus.io_rd_data, 16'h2000);

    // Reset with 3 queued entries and a read in flight
    bus.vid_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_io(16'h8180 + 16'(i), 1'b1, 16'h00A0 + 16'(i));
      tick();
    end
    set_io(16'h0, 1'b0, 16'h0);
    #1;
    check("q3_status", bus.io_rd_data, 16'h0003);
    check("q3_vvalid", bus.vid_valid, 1'b1);
    reset = 1'b0;
    #1;
    check("q3_rst_we", bus.ram_we, 1'b0);
    check("q3_rst_grant", bus.vid_grant, 1'b0);
    tick();
    reset = 1'b1;
    bus.vid_req = 1'b0;
    #1;
    check("q3_after_status", bus.io_rd_data, 16'h2000);
    check("q3_after_vvalid", bus.vid_valid, 1'b0);
    check("q3_after_we", bus.ram_we, 1'b0);
    repeat (12) tick();
    check("discarded_writes", hi_writes, 0);
    check("idle_we", bus.ram_we, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sprite_io_arbiter.md
Name: sprite_io_arbiter

Overview:
- Shares one single-port, registered-read sprite attribute RAM between two requesters: the stack machine's I/O write bus and the video sprite renderer.
- CPU I/O writes are posted into a small FIFO, so the CPU never stalls. The CPU bus has no wait state.
- The video renderer gets read priority, bounded by a starvation limit that guarantees FIFO draining.
- Sits between the StackMachine io_* ports and the sprite RAM / scanout logic.

Parameters:
- DATA_WIDTH, 16, CPU and RAM data width.
- RAM_AW, 9, sprite RAM address width.
- IO_BASE, 4'h8, value of io_addr[15:12] that selects this block.
- FIFO_DEPTH, 4, posted-write FIFO entries (power of 2).
- STARVE_LIMIT, 8, maximum consecutive video grants while the FIFO is non-empty.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- io_addr  in  16  CPU I/O address
- io_write  in  1  CPU I/O write strobe (one cycle per store)
- io_wr_data  in  DATA_WIDTH  CPU write data
- io_rd_data  out  DATA_WIDTH  status word (combinational)
- vid_req  in  1  renderer read request
- vid_addr  in  RAM_AW  renderer read address
- vid_grant  out  1  request accepted this cycle (combinational)
- vid_valid  out  1  vid_rd_data valid (one cycle after grant)
- vid_rd_data  out  DATA_WIDTH  read data
- ram_addr  out  RAM_AW  RAM address
- ram_we  out  1  RAM write enable
- ram_wr_data  out  DATA_WIDTH  RAM write data
- ram_rd_data  in  DATA_WIDTH  RAM registered read data

Behaviour:
- Reset is sampled on rising clock with reset==0:
  - FIFO is emptied; pending posted writes are discarded.
  - overflow=0, starve_cnt=0, vid_valid=0.
  - ram_we=0, vid_grant=0, vid_rd_data=0.
- sel = (io_addr[15:12]==IO_BASE).
- Status address: sel && io_addr[11:0]==12'hFFF.
- Data address: sel && not the status address. RAM address = io_addr[RAM_AW-1:0].
- Push: io_write && data address.
  - Entry {addr, data} is accepted if count<FIFO_DEPTH, or if a pop occurs the same cycle.
  - Otherwise the write is dropped and overflow is set (sticky).
- Status write: io_write && status address && io_wr_data[0]==1 clears overflow. Nothing is enqueued.
  - If an overflow event and a clear occur in the same cycle, set wins.
- io_rd_data, driven every cycle regardless of address:
  - bit15 = overflow, bit14 = full, bit13 = empty.
  - [3:0] = count (zero-extended). All other bits are 0.
- Per-cycle arbitration (combinational, evaluated on registered state):
  - W (write slot) = !empty && (!vid_req || starve_cnt==STARVE_LIMIT).
  - G (video slot) = vid_req && !W.
  - W: ram_we=1; ram_addr/ram_wr_data come from the FIFO head; pop; starve_cnt<=0.
  - G: vid_grant=1; ram_addr=vid_addr; ram_we=0. If !empty, starve_cnt<=starve_cnt+1.
  - Idle: ram_we=0, ram_addr=vid_addr.
  - If the FIFO becomes empty, starve_cnt<=0.
- Video read: vid_valid<=G. ram_rd_data is passed through to vid_rd_data the cycle after the grant.
  - The renderer must hold vid_req/vid_addr until it sees vid_grant.
- Write-to-read ordering:
  - An entry pushed in cycle N can be popped no earlier than N+1. There is no FIFO bypass.
  - A video read issued after a RAM write to the same address returns the new data. The RAM must be read-after-write coherent across cycles.
- FIFO pointers wrap modulo FIFO_DEPTH. count is held in a separate register of width log2(FIFO_DEPTH)+1.
- starve_cnt never exceeds STARVE_LIMIT.
- Worst-case drain latency per entry is STARVE_LIMIT+1 cycles.
- Non-selected io_addr values (RAM space, other I/O) are ignored.

Test Plan:
- Reset, then a CPU write to 0x8005 with data 0x1234 and vid_req=0:
  - next cycle ram_we=1, ram_addr=5, ram_wr_data=0x1234;
  - io_rd_data shows empty=1 after the pop.
- vid_req=1 held with vid_addr=5 after that write:
  - vid_grant=1 in the same cycle;
  - vid_valid=1 with vid_rd_data=0x1234 the following cycle.
- vid_req held continuously, plus one CPU write to 0x8010:
  - 8 consecutive grants, then the 9th cycle is a write slot (vid_grant=0, ram_we=0→1, ram_addr=0x10);
  - the following cycle grants video again.
- vid_req held, 5 back-to-back CPU writes with no pop:
  - the 5th is dropped;
  - io_rd_data=0xC004 (overflow, full, count 4).
- Write 0x0001 to 0x8FFF:
  - overflow clears (bit15=0);
  - FIFO count unchanged.
- reset=0 pulsed for one cycle with 3 entries queued and vid_valid=1:
  - the following cycle io_rd_data=0x2000;
  - vid_valid=0, ram_we=0;
  - no queued write ever reaches the RAM.
